// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types for the scan generator.
// Defaults describe the 640x480 @ 60 Hz mode.
package vga_pkg;

   typedef struct packed {
      int h_active;
      int h_fp;
      int h_sync;
      int h_bp;
      int v_active;
      int v_fp;
      int v_sync;
      int v_bp;
   } vga_timing_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam vga_timing_t VGA_640X480 = '{
      h_active: DEF_H_ACTIVE,
      h_fp:     DEF_H_FP,
      h_sync:   DEF_H_SYNC,
      h_bp:     DEF_H_BP,
      v_active: DEF_V_ACTIVE,
      v_fp:     DEF_V_FP,
      v_sync:   DEF_V_SYNC,
      v_bp:     DEF_V_BP
   };

   localparam int DEF_H_TOTAL =
      DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL =
      DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam int DEF_H_W   = $clog2(DEF_H_TOTAL);
   localparam int DEF_V_W   = $clog2(DEF_V_TOTAL);
   localparam int DEF_DIV_W = $clog2(2);

endpackage

// File: rtl/vga_scan_gen_if.sv
// Video output bundle from the scan generator to the DAC side.
// master drives, slave observes.
interface vga_scan_gen_if #(
   parameter int ADDR_W = 18
);
   logic              vgaclk;
   logic              pix_ce;
   logic              hsync;
   logic              vsync;
   logic              sync_b;
   logic              blank_b;
   logic [ADDR_W-1:0] pxl_addr;
   logic              frame_start;
   logic              line_start;

   modport master (
      output vgaclk, pix_ce, hsync, vsync, sync_b,
      output blank_b, pxl_addr, frame_start, line_start
   );

   modport slave (
      input vgaclk, pix_ce, hsync, vsync, sync_b,
      input blank_b, pxl_addr, frame_start, line_start
   );
endinterface

// File: rtl/pix_ce_gen.sv
// Pixel divider: one-clk pixel strobe plus a 50% duty pixel clock.
// ce_nx is the strobe value that will be registered at the next edge.
module pix_ce_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic pix_ce,
   output logic ce_nx,
   output logic vgaclk
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div;
   logic [DW-1:0] div_nx;

   always_comb begin
      div_nx = div + DW'(1);
      if (!enable || div == DW'(CLK_DIV - 1)) begin
         div_nx = '0;
      end
      ce_nx = enable && (div_nx == DW'(CLK_DIV - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div    <= '0;
         pix_ce <= 1'b0;
         vgaclk <= 1'b0;
      end else begin
         div    <= div_nx;
         pix_ce <= ce_nx;
         vgaclk <= enable && (div_nx >= DW'(CLK_DIV / 2));
      end
   end
endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan: pixel/line counters, sync/blank decode and
// multiplier-free framebuffer address generation.
module vga_scan_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_FP        = DEF_H_FP,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BP        = DEF_H_BP,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int V_FP        = DEF_V_FP,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BP        = DEF_V_BP,
   parameter int CLK_DIV     = 2,
   parameter int SCALE_SHIFT = 1,
   parameter int ADDR_W      = 18,
   parameter bit HSYNC_POL   = 1'b0,
   parameter bit VSYNC_POL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   vga_scan_gen_if.master vga
);
   localparam vga_timing_t TIM = '{
      h_active: H_ACTIVE, h_fp: H_FP,
      h_sync:   H_SYNC,   h_bp: H_BP,
      v_active: V_ACTIVE, v_fp: V_FP,
      v_sync:   V_SYNC,   v_bp: V_BP
   };

   localparam int H_TOTAL =
      TIM.h_active + TIM.h_fp + TIM.h_sync + TIM.h_bp;
   localparam int V_TOTAL =
      TIM.v_active + TIM.v_fp + TIM.v_sync + TIM.v_bp;
   localparam int HW    = $clog2(H_TOTAL);
   localparam int VW    = $clog2(V_TOTAL);
   localparam int ROW   = H_ACTIVE >> SCALE_SHIFT;
   localparam int SMASK = (1 << SCALE_SHIFT) - 1;
   localparam int FB    = ROW * (V_ACTIVE >> SCALE_SHIFT);
   localparam int HS0   = H_ACTIVE + H_FP;
   localparam int HS1   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS0   = V_ACTIVE + V_FP;
   localparam int VS1   = V_ACTIVE + V_FP + V_SYNC;

   if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
      $error("CLK_DIV must be even and at least 2");
   end
   if ((H_ACTIVE & SMASK) != 0 || (V_ACTIVE & SMASK) != 0)
   begin : g_bad_scale
      $error("active area not divisible by the scale");
   end
   if (longint'(FB) > (longint'(1) << ADDR_W)) begin : g_bad_addr
      $error("framebuffer does not fit in ADDR_W");
   end
   if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
      $error("porch and sync widths must be nonzero");
   end

   logic              ce;
   logic              ce_nx;
   logic              vgaclk_q;
   logic [HW-1:0]     hcnt, h_nx;
   logic [VW-1:0]     vcnt, v_nx, v_inc;
   logic [ADDR_W-1:0] base, base_nx;
   logic              vis, hs, vs;
   logic              blank_q, fs_q, ls_q, hs_q, vs_q;
   logic [ADDR_W-1:0] addr_q;

   pix_ce_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_ce (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .pix_ce (ce),
      .ce_nx  (ce_nx),
      .vgaclk (vgaclk_q)
   );

   // base tracks (vcnt >> SCALE_SHIFT) * ROW, stepping once per
   // scaled row so no multiplier is needed.
   always_comb begin
      h_nx    = hcnt;
      v_nx    = vcnt;
      v_inc   = vcnt + VW'(1);
      base_nx = base;
      if (!enable) begin
         h_nx    = '0;
         v_nx    = '0;
         base_nx = '0;
      end else if (ce) begin
         if (hcnt == HW'(H_TOTAL - 1)) begin
            h_nx = '0;
            if (vcnt == VW'(V_TOTAL - 1)) begin
               v_nx    = '0;
               base_nx = '0;
            end else begin
               v_nx = v_inc;
               if (v_inc < VW'(V_ACTIVE) &&
                   (v_inc & VW'(SMASK)) == '0) begin
                  base_nx = base + ADDR_W'(ROW);
               end
            end
         end else begin
            h_nx = hcnt + HW'(1);
         end
      end
      vis = enable && h_nx < HW'(H_ACTIVE) &&
            v_nx < VW'(V_ACTIVE);
      hs  = enable && h_nx >= HW'(HS0) && h_nx < HW'(HS1);
      vs  = enable && v_nx >= VW'(VS0) && v_nx < VW'(VS1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt    <= '0;
         vcnt    <= '0;
         base    <= '0;
         blank_q <= 1'b0;
         addr_q  <= '0;
         fs_q    <= 1'b0;
         ls_q    <= 1'b0;
         hs_q    <= ~HSYNC_POL;
         vs_q    <= ~VSYNC_POL;
      end else begin
         hcnt    <= h_nx;
         vcnt    <= v_nx;
         base    <= base_nx;
         blank_q <= vis;
         addr_q  <= vis ?
                    base_nx + ADDR_W'(h_nx >> SCALE_SHIFT) : '0;
         fs_q    <= ce_nx && h_nx == '0 && v_nx == '0;
         ls_q    <= ce_nx && h_nx == '0;
         hs_q    <= hs ? HSYNC_POL : ~HSYNC_POL;
         vs_q    <= vs ? VSYNC_POL : ~VSYNC_POL;
      end
   end

   assign vga.vgaclk      = vgaclk_q;
   assign vga.pix_ce      = ce;
   assign vga.hsync       = hs_q;
   assign vga.vsync       = vs_q;
   assign vga.sync_b      = 1'b0;
   assign vga.blank_b     = blank_q;
   assign vga.pxl_addr    = addr_q;
   assign vga.frame_start = fs_q;
   assign vga.line_start  = ls_q;
endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen on a 14x8 raster with a
// time-indexed reference model and randomized reset/enable upsets.
module tb_vga_scan_gen;
   localparam int HA = 8, HF = 2, HS = 3, HB = 1;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int CD = 2;
   localparam int SS = 1;
   localparam int AW = 8;
   localparam int NCYC = 4400;

   typedef struct packed {
      logic          vgaclk;
      logic          pix_ce;
      logic          hsync;
      logic          vsync;
      logic          sync_b;
      logic          blank_b;
      logic [AW-1:0] addr;
      logic          fs;
      logic          ls;
   } obs_t;

   typedef struct {
      obs_t o;
      int   k;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   int   checks = 0;
   int   errors = 0;
   bit   done = 1'b0;
   exp_t q[$];
   int   max_addr = 0;

   vga_scan_gen_if #(.ADDR_W(AW)) vif ();

   vga_scan_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .CLK_DIV (CD), .SCALE_SHIFT (SS), .ADDR_W (AW),
      .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .vga    (vif)
   );

   always #5 clk = ~clk;

   // k = enabled edges since the last reset/idle edge
   function automatic obs_t model(input int k);
      obs_t o;
      int d, p, h, v;
      bit vis;
      o = '0;
      o.hsync = 1'b1;
      o.vsync = 1'b1;
      if (k != 0) begin
         d = k % CD;
         p = k / CD;
         h = p % HT;
         v = (p / HT) % VT;
         vis = (h < HA) && (v < VA);
         o.pix_ce  = (d == CD - 1);
         o.vgaclk  = (d >= CD / 2);
         o.hsync   = !(h >= HA + HF && h < HA + HF + HS);
         o.vsync   = !(v >= VA + VF && v < VA + VF + VS);
         o.blank_b = vis;
         o.addr    = vis ?
            AW'((v >> SS) * (HA >> SS) + (h >> SS)) : '0;
         o.fs = o.pix_ce && h == 0 && v == 0;
         o.ls = o.pix_ce && h == 0;
      end
      return o;
   endfunction

   initial begin
      int  k, p, h, v;
      bit  hit;
      exp_t e;
      k = 0;
      hit = 1'b0;
      for (int c = 0; c < NCYC; c++) begin
         p = k / CD;
         h = p % HT;
         v = (p / HT) % VT;
         reset  = 1'b0;
         enable = 1'b1;
         if (c < 3) begin
            reset  = 1'b1;
            enable = (c == 1);
         end else if (c >= 700 && !hit && k != 0 &&
                      h == 9 && v == 5) begin
            reset = 1'b1;
            hit   = 1'b1;
         end else if (c >= 1200 && c < 1205) begin
            enable = 1'b0;
         end else if (c >= 1500 && c < 3500) begin
            reset  = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 149) != 0);
         end
         if (reset || !enable) k = 0;
         else k = k + 1;
         e.o = model(k);
         e.k = k;
         q.push_back(e);
         @(posedge clk);
         @(negedge clk);
      end
      done = 1'b1;
   end

   initial begin
      exp_t e;
      obs_t a;
      int fs_cnt, ls_cnt, lines;
      bit fs_arm, ls_arm;
      fs_cnt = 0; ls_cnt = 0; lines = 0;
      fs_arm = 1'b0; ls_arm = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() == 0) begin
            if (!done) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_empty at %0t", $time);
            end
         end else begin
            e = q.pop_front();
            a = '{vif.vgaclk, vif.pix_ce, vif.hsync, vif.vsync,
                  vif.sync_b, vif.blank_b, vif.pxl_addr,
                  vif.frame_start, vif.line_start};
            checks++;
            if (a !== e.o) begin
               errors++;
               $display("FAIL outputs k=%0d t=%0t act=%b exp=%b",
                        e.k, $time, a, e.o);
            end
            if (int'(vif.pxl_addr) > max_addr)
               max_addr = int'(vif.pxl_addr);
            if (e.k == 0) begin
               fs_arm = 1'b0;
               ls_arm = 1'b0;
            end
            fs_cnt++;
            ls_cnt++;
            if (vif.frame_start === 1'b1) begin
               if (fs_arm) begin
                  checks++;
                  if (fs_cnt != HT * VT * CD) begin
                     errors++;
                     $display("FAIL frame_period act=%0d exp=%0d",
                              fs_cnt, HT * VT * CD);
                  end
                  checks++;
                  if (lines != VT) begin
                     errors++;
                     $display("FAIL lines_per_frame act=%0d exp=%0d",
                              lines, VT);
                  end
               end
               fs_cnt = 0;
               lines  = 0;
               fs_arm = (e.k != 0);
            end
            if (vif.line_start === 1'b1) begin
               if (ls_arm) begin
                  checks++;
                  if (ls_cnt != HT * CD) begin
                     errors++;
                     $display("FAIL line_period act=%0d exp=%0d",
                              ls_cnt, HT * CD);
                  end
               end
               ls_cnt = 0;
               lines++;
               ls_arm = (e.k != 0);
            end
         end
      end
   end

   initial begin
      wait (done);
      @(posedge clk);
      #2;
      checks++;
      if (max_addr != 7) begin
         errors++;
         $display("FAIL max_pxl_addr act=%0d exp=7", max_addr);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #((NCYC + 100) * 10 * 2);
      $display("FAIL timeout at %0t", $time);
      $fatal(1, "bench timeout");
   end
endmodule
